// File: rtl/instr_enc_if.sv
// Valid/ready stream bundle for instr_field_encoder: decoded fields in, packed MIPS word out.
interface instr_enc_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [5:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [5:0]  in_funct;
  logic [31:0] in_value;
  logic        in_sig;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_fmt, in_op, in_rs, in_rt, in_rd, in_funct, in_value, in_sig, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_op, in_rs, in_rt, in_rd, in_funct, in_value, in_sig, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/instr_field_encoder.sv
// Packs decoded fields back into a 32-bit MIPS word with extender range checks, S1 register + FWFT FIFO.
// Optional INSTR_ENC_STRICT_EN: erroneous words are counted but dropped instead of emitted.
module instr_field_encoder #(
  parameter int         FIFO_DEPTH = 2,
  parameter int         ERR_CNT_W  = 8,
  parameter logic [3:0] JT_REGION  = 4'b1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_enc_if.slave           bus,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
`ifdef INSTR_ENC_STRICT_EN
  localparam int ENTRY_W = 32;
`else
  localparam int ENTRY_W = 33;
`endif

  typedef enum logic [1:0] {FMT_R = 2'd0, FMT_I = 2'd1, FMT_SHIFT = 2'd2, FMT_J = 2'd3} fmt_e;

  typedef struct packed {
    fmt_e        fmt;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [31:0] value;
    logic        sig;
  } s1_t;

  function automatic logic [31:0] encode_word(input s1_t s);
    logic [31:0] w;
    case (s.fmt)
      FMT_R:     w = {6'b0, s.rs, s.rt, s.rd, 5'b0, s.funct};
      FMT_I:     w = {s.op, s.rs, s.rt, s.value[15:0]};
      FMT_SHIFT: w = {6'b0, 5'b0, s.rt, s.rd, s.value[4:0], s.funct};
      default:   w = {s.op, s.value[27:2]};
    endcase
    return w;
  endfunction

  // Error means the decode-side extender could not reproduce value from the emitted field.
  function automatic logic range_err(input s1_t s);
    logic e;
    case (s.fmt)
      FMT_R:     e = 1'b0;
      FMT_I:     e = s.sig ? !((&s.value[31:15]) || !(|s.value[31:15])) : (|s.value[31:16]);
      FMT_SHIFT: e = s.sig ? !((&s.value[31:4]) || !(|s.value[31:4])) : (|s.value[31:5]);
      default:   e = (|s.value[1:0]) || (s.value[31:28] != JT_REGION);
    endcase
    return e;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
    return (&c) ? c : c + ERR_CNT_W'(1);
  endfunction

  logic                 s1_valid_q, s1_valid_d;
  s1_t                  s1_q, s1_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]   entry_d, rd_entry;
  logic [31:0]          enc_word;
  logic                 enc_err, out_valid_int, pop, fifo_can_take, push_ok, push, accept;

  assign enc_word      = encode_word(s1_q);
  assign enc_err       = range_err(s1_q);
  assign entry_d       = ENTRY_W'({enc_err, enc_word});
  assign out_valid_int = (count_q != '0);
  assign pop           = out_valid_int & bus.out_ready;
  assign fifo_can_take = (count_q < DEPTH_C) | pop;
  assign push_ok       = s1_valid_q & fifo_can_take;
`ifdef INSTR_ENC_STRICT_EN
  assign push          = push_ok & ~enc_err;
`else
  assign push          = push_ok;
`endif
  assign bus.in_ready  = ~s1_valid_q | fifo_can_take;
  assign accept        = bus.in_valid & bus.in_ready;

  always_comb begin
    s1_d       = '{fmt: fmt_e'(bus.in_fmt), op: bus.in_op, rs: bus.in_rs, rt: bus.in_rt,
                   rd: bus.in_rd, funct: bus.in_funct, value: bus.in_value, sig: bus.in_sig};
    s1_valid_d = s1_valid_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    err_cnt_d  = err_cnt_q;
    if (push_ok)
      s1_valid_d = 1'b0;
    if (accept)
      s1_valid_d = 1'b1;
    if (push)
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && enc_err)
      err_cnt_d = sat_inc(err_cnt_q);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // S1 / FIFO control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      s1_q <= s1_d;
    if (push)
      mem_q[wr_ptr_q] <= entry_d;
  end

  assign rd_entry      = mem_q[rd_ptr_q];
  assign bus.out_valid = out_valid_int;
  assign bus.out_instr = out_valid_int ? rd_entry[31:0] : 32'h0;
`ifdef INSTR_ENC_STRICT_EN
  assign bus.out_err   = 1'b0;
`else
  assign bus.out_err   = out_valid_int & rd_entry[32];
`endif
  assign err_cnt       = err_cnt_q;
  assign busy          = s1_valid_q | out_valid_int;
endmodule

// File: tb/tb_instr_field_encoder.sv
// Randomized scoreboard bench for instr_field_encoder against an arithmetic reference model.
module tb_instr_field_encoder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] err_cnt;
  logic       busy;

  instr_enc_if bus();

  instr_field_encoder #(.FIFO_DEPTH(2), .ERR_CNT_W(8), .JT_REGION(4'b1000)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] instr; logic err; } exp_t;
  exp_t        sb[$];
  int          pop_cyc[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          exp_err = 0;
  logic [31:0] last_instr = 32'h0;
  bit          rnd_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: outputs are stable at the falling edge, handshake completes on the next rise.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_word: got %h expected none", bus.out_instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_instr", bus.out_instr, e.instr);
        check("out_err", {31'b0, bus.out_err}, {31'b0, e.err});
      end
      last_instr = bus.out_instr;
      pop_cyc.push_back(cyc);
    end
  end

  function automatic void model(input logic [1:0] fmt, input logic [5:0] op, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] funct,
                                input logic [31:0] value, input logic sig,
                                output logic [31:0] word, output logic err);
    longint unsigned w, uv, lop, lrs, lrt, lrd, lf;
    longint sv;
    uv = {32'd0, value};
    sv = longint'($signed(value));
    lop = {58'd0, op}; lrs = {59'd0, rs}; lrt = {59'd0, rt}; lrd = {59'd0, rd}; lf = {58'd0, funct};
    case (fmt)
      2'd0: begin
        w = lrs * (64'd1 << 21) + lrt * (64'd1 << 16) + lrd * (64'd1 << 11) + lf;
        err = 1'b0;
      end
      2'd1: begin
        w = lop * (64'd1 << 26) + lrs * (64'd1 << 21) + lrt * (64'd1 << 16) + uv % 65536;
        err = sig ? (sv < -32768 || sv > 32767) : (uv > 65535);
      end
      2'd2: begin
        w = lrt * (64'd1 << 16) + lrd * (64'd1 << 11) + (uv % 32) * 64 + lf;
        err = sig ? (sv < -16 || sv > 15) : (uv > 31);
      end
      default: begin
        w = lop * (64'd1 << 26) + (uv % (64'd1 << 28)) / 4;
        err = (uv % 4 != 0) || (uv / (64'd1 << 28) != 8);
      end
    endcase
    word = w[31:0];
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [1:0] fmt, input logic [5:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] funct,
                      input logic [31:0] value, input logic sig);
    exp_t e;
    int   n;
    bit   ok;
    bus.in_fmt = fmt; bus.in_op = op; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
    bus.in_funct = funct; bus.in_value = value; bus.in_sig = sig; bus.in_valid = 1'b1;
    n = 0; ok = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
      n++;
      if (n > 60) break;
      @(posedge clk); #1;
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 60 cycles");
    end else begin
      model(fmt, op, rs, rt, rd, funct, value, sig, e.instr, e.err);
      if (e.err) exp_err++;
`ifdef INSTR_ENC_STRICT_EN
      if (!e.err) sb.push_back(e);
`else
      sb.push_back(e);
`endif
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n = 0;
    bus.out_ready = 1'b1;
    while (sb.size() != 0 || busy) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL drain_timeout: got pending=%0d expected 0", sb.size());
        sb.delete();
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_errcnt(input string name);
    check(name, {24'b0, err_cnt}, (exp_err > 255) ? 32'd255 : 32'(exp_err));
  endtask

  function automatic logic [31:0] rand_value();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($signed(32'($urandom_range(0, 63))) - 32);
      2: return {4'b1000, 28'($urandom)} ^ {30'b0, ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00};
      default: return 32'($signed(32'($urandom_range(0, 80000))) - 40000);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_fmt = 2'd0; bus.in_op = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
    bus.in_funct = '0; bus.in_value = '0; bus.in_sig = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_out_err", {31'b0, bus.out_err}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;

    // Directed I-format with latency check
    bus.out_ready = 1'b1;
    send(2'd1, 6'h08, 5'd1, 5'd2, 5'd0, 6'd0, 32'hFFFF_FFFC, 1'b1);
    check("lat_not_yet", {31'b0, bus.out_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_valid", {31'b0, bus.out_valid}, 32'd1);
    drain();
    check("i_word", last_instr, 32'h2022_FFFC);

    send(2'd3, 6'h02, 5'd0, 5'd0, 5'd0, 6'd0, 32'h8000_0040, 1'b0);
    drain();
    check("j_word", last_instr, 32'h0800_0010);
    send(2'd3, 6'h02, 5'd0, 5'd0, 5'd0, 6'd0, 32'h0000_0040, 1'b0);
    drain();
    check("err_cnt_j", {24'b0, err_cnt}, 32'd1);

    send(2'd2, 6'h3F, 5'd9, 5'd3, 5'd4, 6'd0, 32'd5, 1'b0);
    drain();
    check("shift_word", last_instr, 32'h0003_2140);
    send(2'd1, 6'h0D, 5'd1, 5'd1, 5'd0, 6'd0, 32'h0001_0000, 1'b0);
    drain();
    check("err_cnt_i", {24'b0, err_cnt}, 32'd2);

    // Backpressure: three accepts fill S1 + FIFO, fourth must stall
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(2'd0, 6'd0, 5'(i + 1), 5'(i + 2), 5'(i + 3), 6'(i + 32), 32'h0, 1'b0);
    bus.in_fmt = 2'd0; bus.in_rs = 5'd7; bus.in_rt = 5'd8; bus.in_rd = 5'd9; bus.in_funct = 6'd42;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check("bp_busy", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    pop_cyc.delete();
    bus.out_ready = 1'b1;
    send(2'd0, 6'd0, 5'd7, 5'd8, 5'd9, 6'd42, 32'h0, 1'b0);
    drain();
    check("bp_pops", 32'(pop_cyc.size()), 32'd4);
    if (pop_cyc.size() == 4)
      check("bp_back_to_back", 32'(pop_cyc[3] - pop_cyc[0]), 32'd3);

    // Randomized traffic with random output stalls
    rnd_ready = 1;
    for (int i = 0; i < 300; i++)
      send(2'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
           rand_value(), 1'($urandom));
    rnd_ready = 0;
    drain();
    check_errcnt("err_cnt_random");

    // Saturation with a stream of failing words
    for (int i = 0; i < 260; i++) begin
      case (i % 3)
        0: send(2'd1, 6'h08, 5'd1, 5'd2, 5'd0, 6'd0, 32'h0002_0000 + 32'(i), 1'b0);
        1: send(2'd2, 6'd0, 5'd0, 5'd3, 5'd4, 6'd2, 32'h0000_0020 + 32'(i), 1'b1);
        default: send(2'd3, 6'h03, 5'd0, 5'd0, 5'd0, 6'd0, 32'h4000_0000 + 32'(i * 4), 1'b0);
      endcase
    end
    drain();
    check("err_cnt_sat", {24'b0, err_cnt}, 32'd255);
    send(2'd3, 6'h02, 5'd0, 5'd0, 5'd0, 6'd0, 32'h8000_0001, 1'b0);
    drain();
    check("err_cnt_hold", {24'b0, err_cnt}, 32'd255);

    // Mid-stream reset with three words buffered
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(2'd0, 6'd0, 5'd3, 5'd4, 5'd5, 6'(i), 32'h0, 1'b0);
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_err_cnt", {24'b0, err_cnt}, 32'd0);
    sb.delete();
    exp_err = 0;
    pop_cyc.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_no_output", 32'(pop_cyc.size()), 32'd0);
    send(2'd1, 6'h23, 5'd5, 5'd6, 5'd0, 6'd0, 32'h0000_0010, 1'b0);
    drain();
    check("post_rst_word", last_instr, 32'h8CA6_0010);
    check_errcnt("post_rst_err_cnt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/instr_field_encoder.md
Name: instr_field_encoder

Overview:
- Packs decoded instruction fields plus a full 32-bit immediate, shift amount or jump byte address back into a 32-bit MIPS instruction word.
- Performs the inverse of the decode-side 16→32 extender, 5→32 extender and 26→32 jump-target extender.
- Range-checks each value against what those extenders can reproduce, so decoding the emitted word returns the original value.
- Feeds the instruction-memory loader and self-test sequencer through a valid/ready stream with a registered input stage and a small output FIFO.

Parameters:
- FIFO_DEPTH, 2: output FIFO entries; power of two, ≥2.
- ERR_CNT_W, 8: width of the saturating error counter.
- JT_REGION, 4'b1000: required value[31:28] for J-format targets (the jump extender forces these bits).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word offered
- in_ready  out  1  encoder accepts input this cycle
- in_fmt  in  2  0=R, 1=I, 2=SHIFT, 3=J
- in_op  in  6  opcode (I/J); ignored for R/SHIFT, which emit 6'b0
- in_rs  in  5  rs field
- in_rt  in  5  rt field
- in_rd  in  5  rd field
- in_funct  in  6  funct field (R/SHIFT)
- in_value  in  32  immediate / shift amount / jump byte address
- in_sig  in  1  1=signed range check, 0=zero-extend range check (I, SHIFT)
- out_valid  out  1  encoded word available
- out_ready  in  1  consumer accepts word
- out_instr  out  32  encoded instruction
- out_err  out  1  word failed its range check
- err_cnt  out  ERR_CNT_W  saturating count of failed words
- busy  out  1  S1 or FIFO non-empty

Behaviour:
- Reset (async assert, sync release) clears:
  - S1 valid
  - FIFO pointers and count
  - err_cnt
  - out_valid=0, out_instr=0, out_err=0, busy=0
  - in_ready=1 from the first clock after release.
- Stage S1 registers an accepted input. A transfer occurs when in_valid&in_ready at the clock edge.
- in_ready = !s1_valid | fifo_can_take. fifo_can_take = count<FIFO_DEPTH, or an output pop in the same cycle.
- Encode is combinational from S1. The word is written to the FIFO when s1_valid and fifo_can_take.
- Latency: accept at edge N → out_valid high after edge N+1 when the FIFO is empty.
- Sustained throughput is 1 word/clock.
- Encodings:
  - R: {6'b0, rs, rt, rd, 5'b0, funct}
  - I: {op, rs, rt, value[15:0]}
  - SHIFT: {6'b0, 5'b0, rt, rd, value[4:0], funct}
  - J: {op, value[27:2]}
- Range checks (err=1 on failure):
  - I, sig=1: value[31:15] all equal.
  - I, sig=0: value[31:16]==0.
  - SHIFT, sig=1: value[31:4] all equal.
  - SHIFT, sig=0: value[31:5]==0.
  - J: value[1:0]==0 and value[31:28]==JT_REGION.
  - R: never errs; value is ignored.
- err_cnt increments once per erroneous word when it enters the FIFO. It saturates at all-ones and never wraps.
- FIFO is first-word-fall-through. out_instr/out_err are valid whenever out_valid=1 and are held stable until out_ready.
- Simultaneous push and pop on a full FIFO is legal: count is unchanged, no stall.
- Pointers wrap modulo FIFO_DEPTH.
- Total buffering is FIFO_DEPTH+1 words. With out_ready held low, in_ready drops after FIFO_DEPTH+1 accepts.
- Asserting rst_n low mid-stream discards S1 and FIFO contents immediately. No partial word is emitted after release.
- in_fmt/in_value are don't-care when in_valid=0.

Optional Feature:
- Macro: INSTR_ENC_STRICT_EN.
- When defined:
  - Erroneous words are dropped at the FIFO write point: not stored, not emitted. They are still counted in err_cnt.
  - out_err is tied 0.
  - A dropped word still frees S1 in that cycle.
- When undefined: erroneous words are emitted with out_err=1, and fields are truncated per the encodings above.

Test Plan:
- Reset, then I-format op=6'h08 rs=1 rt=2 value=32'hFFFF_FFFC sig=1, out_ready=1 → out_instr=32'h2022_FFFC, out_err=0, out_valid one cycle after the accept edge.
- J-format op=6'h02 value=32'h8000_0040 → 32'h0800_0010, err=0. Then value=32'h0000_0040 → out_err=1 (or dropped under INSTR_ENC_STRICT_EN), err_cnt=1.
- SHIFT rt=3 rd=4 value=5 funct=0 sig=0 → 32'h0003_2140. I-format sig=0 value=32'h0001_0000 → err, err_cnt increments.
- Backpressure: out_ready=0, offer 4 back-to-back words → 3 accepted, in_ready=0 on the 4th. Raise out_ready → all 4 emitted in order, one per clock, no loss or duplication.
- Saturation: 260 erroneous words → err_cnt=8'hFF and holds. Simultaneous push/pop with a full FIFO keeps count at 2.
- Assert rst_n low with 3 words buffered → out_valid=0 and busy=0 immediately, err_cnt=0. After release, the first new input is emitted correctly.
